sisc_ctrl_mc: RTL and testbench
===============================

// Module: sisc_ctrl_mc
// PURPOSE
//  Parametrised multicycle control FSM for the SISC datapath, the successor to the fixed 7-state controller.
//  Adds parametrised opcode/condition-code widths and request/acknowledge handshakes to instruction and data memory.
//  Adds a programmable memory-wait timeout with a FAULT state, a sticky HALT state, illegal-opcode detection,
//  an early return to FETCH for branch/NOOP, and a two-cycle SWP writeback.
//  Sits between the IR/status register and all datapath muxes, the register file, the PC and the memory write enables.
// PARAMETERS
//  OP_W    4   opcode width; opcodes compare against zero-extended constants
//  CC_W    4   width of mm (condition mask / addressing mode) and stat
//  IMM_MM  8   mm value that selects immediate addressing
//  TIMEOUT 15  max cycles waiting for imem_ack/dmem_ack before FAULT; 0 = wait forever
// PORTS
//  clk          in   1     clock, all state changes on posedge
//  rst          in   1     synchronous, active-high reset
//  start        in   1     leave IDLE (sampled in IDLE only)
//  opcode       in   OP_W  IR opcode field, held stable by IR outside FETCH
//  mm           in   CC_W  IR condition mask / addressing mode
//  stat         in   CC_W  status flags
//  imem_ack     in   1     instruction fetch complete
//  dmem_ack     in   1     data access complete
//  imem_req     out  1     instruction fetch request
//  dmem_req     out  1     data access request
//  ir_load      out  1     load IR
//  pc_write     out  1     PC update enable
//  pc_sel       out  1     1 = branch target, 0 = PC+1
//  br_sel       out  1     1 = absolute target, 0 = relative target
//  rb_sel       out  1     register-file read port B select
//  alu_op       out  2     ALU function
//  wb_sel       out  2     writeback source
//  rf_we        out  1     register-file write enable
//  dm_we        out  1     data-memory write enable
//  mux_16_sel   out  1     memory address source: 1 = immediate
//  swap_ctrl    out  1     latch swap operand
//  retire       out  1     one-cycle pulse when an instruction completes
//  halted       out  1     in HALT
//  fault        out  1     in FAULT
//  state        out  4     current state encoding (debug)
// BEHAVIOUR
//  Registered state. Outputs are combinational from state, opcode, mm and stat.
//  Any output not listed for a state is 0.
//  Opcodes: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15.
//  imm = (mm == IMM_MM).
//  States (encoding): IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 WB2=6 HALT=7 FAULT=8.
//  rst: state<=IDLE and wait counter<=0 on the next posedge, from any state, including mid-handshake.
//   All outputs are 0 in IDLE.
//  IDLE: start -> FETCH.
//  FETCH: imem_req=1. On imem_ack: ir_load=1 and pc_write=1 (pc_sel=0) in that same cycle -> DECODE.
//  DECODE:
//   - taken = |(stat&mm) for BRA/BRR; taken = ~|(stat&mm) for BNE/BNR.
//   - Branch taken: pc_write=1, pc_sel=1, br_sel=1 for BRA/BNE, br_sel=0 for BRR/BNR.
//   - Branch (taken or not) or NOOP -> FETCH with retire=1.
//   - HLT -> HALT. Undefined opcode -> FAULT.
//   - LOD/STR/SWP/ALU -> EXEC. rb_sel=1 for STR/SWP.
//  EXEC:
//   - alu_op: ALU -> imm?01:00; LOD/STR -> imm?11:10.
//   - SWP: swap_ctrl=1, wb_sel=2.
//   - ALU -> WB; others -> MEM.
//   - rb_sel=1 for STR/SWP.
//  MEM:
//   - dmem_req=1, mux_16_sel=imm.
//   - dm_we=1 for STR only, and only in the ack cycle.
//   - alu_op and rb_sel are held from EXEC.
//   - On dmem_ack: STR -> FETCH with retire=1; LOD -> WB; SWP -> WB with rf_we=1, wb_sel=2.
//  WB:
//   - ALU: rf_we=1, wb_sel=0 -> FETCH, retire=1.
//   - LOD: rf_we=1, wb_sel=1 -> FETCH, retire=1.
//   - SWP: rf_we=1, wb_sel=3 -> WB2.
//  WB2 (SWP only): rf_we=1, wb_sel=3, swap_ctrl=0 -> FETCH, retire=1.
//  HALT: halted=1, no outputs, start ignored; exit only via rst.
//  FAULT: fault=1, no outputs; exit only via rst.
//  Wait counter:
//   - Cleared on entry to FETCH/MEM; increments each cycle req=1 and ack=0.
//   - TIMEOUT>0 and counter==TIMEOUT with ack still 0 -> FAULT.
//   - ack in the same cycle as the limit wins, no fault.
//  Ack while no request is outstanding is ignored. Request holds until ack; no request is withdrawn except by rst/FAULT.
// TESTING
//  rst=1 for 2 cycles, start=1: state 0->1; all outputs 0 during reset.
//  ALU, mm=8, imem_ack=1 at cycle 1: FETCH(ir_load, pc_write) -> DECODE -> EXEC alu_op=01 -> WB rf_we=1 wb_sel=0, retire; 4 cycles.
//  BNE, mm=4'b0011, stat=4'b0100: DECODE pc_write=1, pc_sel=1, br_sel=1, retire -> FETCH.
//   Same with stat=4'b0001: pc_write=0.
//  STR with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles, dm_we only in the ack cycle -> FETCH.
//  TIMEOUT=15, LOD with dmem_ack held low: FAULT entered after 16 MEM cycles; ack arriving in cycle 16 goes to WB instead.
//  Illegal opcode 9 -> FAULT. HLT -> halted=1 stuck through start pulses.
//   SWP: MEM wb_sel=2 rf_we=1, then WB and WB2 wb_sel=3. rst asserted mid-MEM -> IDLE next cycle.

Source files
------------

// File: rtl/sisc_ctrl_mc.sv
// Multicycle control FSM for the SISC datapath.
// It drives the instruction/data memory handshakes, the datapath selects, the
// register-file and data-memory write enables and the PC update. It also has a
// memory-wait timeout that leads to FAULT.
module sisc_ctrl_mc #(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned CC_W    = 4,
    parameter int unsigned IMM_MM  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    input  logic [CC_W-1:0] mm,
    input  logic [CC_W-1:0] stat,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            ir_load,
    output logic            pc_write,
    output logic            pc_sel,
    output logic            br_sel,
    output logic            rb_sel,
    output logic [1:0]      alu_op,
    output logic [1:0]      wb_sel,
    output logic            rf_we,
    output logic            dm_we,
    output logic            mux_16_sel,
    output logic            swap_ctrl,
    output logic            retire,
    output logic            halted,
    output logic            fault,
    output logic [3:0]      state
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [OP_W-1:0] OP_NOOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SWP  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BRA  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BNR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ALU  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_HLT  = OP_W'(15);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_WB2    = 4'd6,
        S_HALT   = 4'd7,
        S_FAULT  = 4'd8
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] wait_cnt;
    logic             imm, cond, timed_out, is_ldst, is_rb;
    logic [1:0]       exec_alu_op;

    assign state     = state_q;
    assign imm       = (mm == CC_W'(IMM_MM));
    assign cond      = |(stat & mm);
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));
    assign is_ldst   = (opcode == OP_LOD) || (opcode == OP_STR);
    assign is_rb     = (opcode == OP_STR) || (opcode == OP_SWP);
    // ALU ops select reg/imm operand; loads/stores select reg/imm address add.
    assign exec_alu_op = (opcode == OP_ALU) ? {1'b0, imm} :
                         is_ldst            ? {1'b1, imm} : 2'b00;

    // State register and wait counter; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state_q <= state_n;
            if (state_n != state_q)
                wait_cnt <= '0;
            else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack))
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Next-state and control outputs decoded from state and IR fields.
    always_comb begin
        state_n    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        br_sel     = 1'b0;
        rb_sel     = 1'b0;
        alu_op     = 2'b00;
        wb_sel     = 2'b00;
        rf_we      = 1'b0;
        dm_we      = 1'b0;
        mux_16_sel = 1'b0;
        swap_ctrl  = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end else if (timed_out) begin
                    state_n = S_FAULT;
                end
            end
            S_DECODE: begin
                rb_sel = is_rb;
                case (opcode)
                    OP_NOOP: begin
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                    OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
                        if (((opcode == OP_BRA) || (opcode == OP_BRR)) ? cond : !cond) begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                            br_sel   = (opcode == OP_BRA) || (opcode == OP_BNE);
                        end
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                    OP_LOD, OP_STR, OP_SWP, OP_ALU: state_n = S_EXEC;
                    OP_HLT:  state_n = S_HALT;
                    default: state_n = S_FAULT;
                endcase
            end
            S_EXEC: begin
                alu_op = exec_alu_op;
                rb_sel = is_rb;
                if (opcode == OP_SWP) begin
                    swap_ctrl = 1'b1;
                    wb_sel    = 2'd2;
                end
                state_n = (opcode == OP_ALU) ? S_WB : S_MEM;
            end
            S_MEM: begin
                dmem_req   = 1'b1;
                mux_16_sel = imm;
                alu_op     = exec_alu_op;
                rb_sel     = is_rb;
                if (dmem_ack) begin
                    if (opcode == OP_STR) begin
                        dm_we   = 1'b1;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end else if (opcode == OP_SWP) begin
                        rf_we   = 1'b1;
                        wb_sel  = 2'd2;
                        state_n = S_WB;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (timed_out) begin
                    state_n = S_FAULT;
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                if (opcode == OP_SWP) begin
                    wb_sel  = 2'd3;
                    state_n = S_WB2;
                end else begin
                    wb_sel  = (opcode == OP_LOD) ? 2'd1 : 2'd0;
                    retire  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_WB2: begin
                rf_we   = 1'b1;
                wb_sel  = 2'd3;
                retire  = 1'b1;
                state_n = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed bench for sisc_ctrl_mc: walks each instruction class through the FSM
// and checks state plus every control output once per cycle.
module tb_sisc_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst, start, imem_ack, dmem_ack;
    logic [3:0] opcode, mm, stat;
    logic       imem_req, dmem_req, ir_load, pc_write, pc_sel, br_sel, rb_sel;
    logic [1:0] alu_op, wb_sel;
    logic       rf_we, dm_we, mux_16_sel, swap_ctrl, retire, halted, fault;
    logic [3:0] state;

    int tests  = 0;
    int failed = 0;

    localparam logic [17:0] M_IMEM  = 18'(1) << 17;
    localparam logic [17:0] M_DMEM  = 18'(1) << 16;
    localparam logic [17:0] M_IRLD  = 18'(1) << 15;
    localparam logic [17:0] M_PCW   = 18'(1) << 14;
    localparam logic [17:0] M_PCSEL = 18'(1) << 13;
    localparam logic [17:0] M_BRSEL = 18'(1) << 12;
    localparam logic [17:0] M_RB    = 18'(1) << 11;
    localparam logic [17:0] M_RFWE  = 18'(1) << 6;
    localparam logic [17:0] M_DMWE  = 18'(1) << 5;
    localparam logic [17:0] M_MUX   = 18'(1) << 4;
    localparam logic [17:0] M_SWAP  = 18'(1) << 3;
    localparam logic [17:0] M_RET   = 18'(1) << 2;
    localparam logic [17:0] M_HALT  = 18'(1) << 1;
    localparam logic [17:0] M_FAULT = 18'(1);

    function automatic logic [17:0] aop(input logic [1:0] v);
        return 18'(v) << 9;
    endfunction

    function automatic logic [17:0] wsel(input logic [1:0] v);
        return 18'(v) << 7;
    endfunction

    sisc_ctrl_mc dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mm(mm), .stat(stat),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
        .rb_sel(rb_sel), .alu_op(alu_op), .wb_sel(wb_sel), .rf_we(rf_we), .dm_we(dm_we),
        .mux_16_sel(mux_16_sel), .swap_ctrl(swap_ctrl), .retire(retire), .halted(halted),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] es, input logic [17:0] eo);
        logic [17:0] o;
        #1;
        o = {imem_req, dmem_req, ir_load, pc_write, pc_sel, br_sel, rb_sel, alu_op, wb_sel,
             rf_we, dm_we, mux_16_sel, swap_ctrl, retire, halted, fault};
        tests++;
        assert (state === es) else begin
            failed++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
        end
        tests++;
        assert (o === eo) else begin
            failed++;
            $error("FAIL %s outputs: observed %05h expected %05h", tag, o, eo);
        end
    endtask

    // In FETCH: present the instruction with imem_ack, check, then move to DECODE.
    task automatic fetch(input string tag, input logic [3:0] op, input logic [3:0] m,
                         input logic [3:0] s);
        opcode   = op;
        mm       = m;
        stat     = s;
        imem_ack = 1'b1;
        chk(tag, 4'd1, M_IMEM | M_IRLD | M_PCW);
        tick();
        imem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        opcode = '0; mm = '0; stat = '0;

        // Reset for two cycles, then start leaves IDLE.
        tick(); chk("rst1", 4'd0, '0);
        tick(); chk("rst2", 4'd0, '0);
        rst = 1'b0;
        chk("idle", 4'd0, '0);
        tick(); start = 1'b0;

        // ALU immediate.
        fetch("alu_fetch", 4'd8, 4'd8, 4'd0);
        chk("alu_dec", 4'd2, '0);
        tick(); chk("alu_exec", 4'd3, aop(2'b01));
        tick(); chk("alu_wb", 4'd5, M_RFWE | wsel(2'd0) | M_RET);
        tick(); chk("alu_next", 4'd1, M_IMEM);

        // BNE taken (stat&mm == 0), absolute target.
        fetch("bne_fetch", 4'd6, 4'b0011, 4'b0100);
        chk("bne_taken", 4'd2, M_PCW | M_PCSEL | M_BRSEL | M_RET);
        tick(); chk("bne_next", 4'd1, M_IMEM);

        // BNE not taken.
        fetch("bnen_fetch", 4'd6, 4'b0011, 4'b0001);
        chk("bne_not", 4'd2, M_RET);
        tick();

        // BRR taken, relative target.
        fetch("brr_fetch", 4'd5, 4'b0011, 4'b0010);
        chk("brr_taken", 4'd2, M_PCW | M_PCSEL | M_RET);
        tick();

        // STR immediate with dmem_ack delayed three cycles.
        fetch("str_fetch", 4'd2, 4'd8, 4'd0);
        chk("str_dec", 4'd2, M_RB);
        tick(); chk("str_exec", 4'd3, M_RB | aop(2'b11));
        for (int i = 0; i < 3; i++) begin
            tick(); chk("str_wait", 4'd4, M_DMEM | M_MUX | M_RB | aop(2'b11));
        end
        tick(); dmem_ack = 1'b1;
        chk("str_ack", 4'd4, M_DMEM | M_MUX | M_RB | aop(2'b11) | M_DMWE | M_RET);
        tick(); dmem_ack = 1'b0;
        chk("str_next", 4'd1, M_IMEM);

        // LOD with ack never arriving: 16 MEM cycles then FAULT.
        fetch("lodt_fetch", 4'd1, 4'd0, 4'd0);
        chk("lodt_dec", 4'd2, '0);
        tick(); chk("lodt_exec", 4'd3, aop(2'b10));
        for (int i = 0; i < 16; i++) begin
            tick(); chk("lodt_wait", 4'd4, M_DMEM | aop(2'b10));
        end
        tick(); chk("lodt_fault", 4'd8, M_FAULT);
        tick(); chk("lodt_stuck", 4'd8, M_FAULT);
        rst = 1'b1; tick(); rst = 1'b0; start = 1'b1;
        chk("lodt_rst", 4'd0, '0);
        tick(); start = 1'b0;

        // LOD with ack in the 16th MEM cycle: ack wins over the limit.
        fetch("lod_fetch", 4'd1, 4'd0, 4'd0);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick(); chk("lod_wait", 4'd4, M_DMEM | aop(2'b10));
        end
        tick(); dmem_ack = 1'b1;
        chk("lod_ack16", 4'd4, M_DMEM | aop(2'b10));
        tick(); dmem_ack = 1'b0;
        chk("lod_wb", 4'd5, M_RFWE | wsel(2'd1) | M_RET);
        tick(); chk("lod_next", 4'd1, M_IMEM);

        // Illegal opcode 9.
        fetch("ill_fetch", 4'd9, 4'd0, 4'd0);
        chk("ill_dec", 4'd2, '0);
        tick(); chk("ill_fault", 4'd8, M_FAULT);
        rst = 1'b1; tick(); rst = 1'b0; start = 1'b1;
        tick(); start = 1'b0;

        // HLT is sticky through start pulses.
        fetch("hlt_fetch", 4'd15, 4'd0, 4'd0);
        tick(); chk("hlt_halt", 4'd7, M_HALT);
        start = 1'b1;
        tick(); chk("hlt_start1", 4'd7, M_HALT);
        tick(); start = 1'b0;
        chk("hlt_start2", 4'd7, M_HALT);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("hlt_rst", 4'd0, '0);
        start = 1'b1; tick(); start = 1'b0;

        // SWP: two-cycle writeback.
        fetch("swp_fetch", 4'd3, 4'd0, 4'd0);
        chk("swp_dec", 4'd2, M_RB);
        tick(); chk("swp_exec", 4'd3, M_RB | M_SWAP | wsel(2'd2));
        tick(); dmem_ack = 1'b1;
        chk("swp_mem", 4'd4, M_DMEM | M_RB | M_RFWE | wsel(2'd2));
        tick(); dmem_ack = 1'b0;
        chk("swp_wb", 4'd5, M_RFWE | wsel(2'd3));
        tick(); chk("swp_wb2", 4'd6, M_RFWE | wsel(2'd3) | M_RET);
        tick(); chk("swp_next", 4'd1, M_IMEM);

        // rst in the middle of a MEM handshake.
        fetch("swpr_fetch", 4'd3, 4'd0, 4'd0);
        tick();
        tick(); chk("swpr_mem", 4'd4, M_DMEM | M_RB);
        rst = 1'b1;
        tick(); chk("swpr_rst", 4'd0, '0);
        rst = 1'b0;
        tick(); chk("swpr_idle", 4'd0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
